// File: rtl/memory_port_arbiter.sv
// Shares one downstream memory port between instruction fetch and data access:
// round-robin grant on conflict, one outstanding transaction, watchdog fault on hang.
module memory_port_arbiter #(
    parameter int CORE            = 0,
    parameter int ADDRESS_BITS    = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int SCAN_CYCLES_MIN = 0,
    parameter int SCAN_CYCLES_MAX = 1000
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic                    i_read,
    input  logic [ADDRESS_BITS-1:0] i_address,
    output logic                    i_ready,
    output logic                    i_valid,
    output logic [DATA_WIDTH-1:0]   i_data,
    output logic                    i_page_fault,
    output logic                    i_access_fault,

    input  logic                    d_read,
    input  logic                    d_write,
    input  logic [ADDRESS_BITS-1:0] d_address,
    input  logic [DATA_WIDTH-1:0]   d_data_in,
    output logic                    d_ready,
    output logic                    d_valid,
    output logic [DATA_WIDTH-1:0]   d_data,
    output logic                    d_page_fault,
    output logic                    d_access_fault,

    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDRESS_BITS-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]   mem_data_out,
    input  logic                    mem_ready,
    input  logic                    mem_valid,
    input  logic [DATA_WIDTH-1:0]   mem_data_in,
    input  logic                    page_fault,
    input  logic                    access_fault,

    input  logic                    scan
);

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
    localparam bit          WATCHDOG_ON   = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } state_t;

    state_t      state;
    logic        last_grant_d;   // 1: data side won the previous grant
    logic        store_pending;  // outstanding data transaction is a store
    logic [15:0] wait_count;     // cycles elapsed since the grant

    logic i_req;
    logic d_req;
    logic can_grant;
    logic grant_i;
    logic grant_d;
    logic own_i;
    logic own_d;
    logic respond;
    logic timeout;
    logic done;

    assign i_req     = i_read;
    assign d_req     = d_read | d_write;
    assign can_grant = !reset && (state == IDLE) && mem_ready;

    // On conflict the side that did not win last time goes first.
    assign grant_i = can_grant && i_req && (!d_req || last_grant_d);
    assign grant_d = can_grant && d_req && (!i_req || !last_grant_d);

    assign own_i   = (state == WAIT_I);
    assign own_d   = (state == WAIT_D);
    assign respond = (own_i || own_d) && (mem_valid || page_fault || access_fault);
    // A real response in the expiry cycle takes priority over the watchdog.
    assign timeout = WATCHDOG_ON && (own_i || own_d) && !respond
                     && (wait_count == TIMEOUT_LIMIT);
    assign done    = respond || timeout;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        i_ready        = grant_i;
        d_ready        = grant_d;
        mem_read       = grant_i || (grant_d && d_read);
        mem_write      = grant_d && d_write;
        mem_address    = '0;
        mem_data_out   = '0;
        i_valid        = 1'b0;
        i_data         = '0;
        i_page_fault   = 1'b0;
        i_access_fault = 1'b0;
        d_valid        = 1'b0;
        d_data         = '0;
        d_page_fault   = 1'b0;
        d_access_fault = 1'b0;

        if (grant_i) begin
            mem_address = i_address;
        end else if (grant_d) begin
            mem_address = d_address;
            if (d_write) begin
                mem_data_out = d_data_in;
            end
        end

        if (own_i && done) begin
            i_valid        = 1'b1;
            i_data         = respond ? mem_data_in : '0;
            i_page_fault   = respond && page_fault;
            i_access_fault = respond ? access_fault : 1'b1;
        end

        if (own_d && done) begin
            d_valid        = 1'b1;
            d_data         = (respond && !store_pending) ? mem_data_in : '0;
            d_page_fault   = respond && page_fault;
            d_access_fault = respond ? access_fault : 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            last_grant_d  <= 1'b1;
            store_pending <= 1'b0;
            wait_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        state        <= WAIT_I;
                        last_grant_d <= 1'b0;
                        wait_count   <= 16'd1;
                    end else if (grant_d) begin
                        state         <= WAIT_D;
                        last_grant_d  <= 1'b1;
                        store_pending <= d_write;
                        wait_count    <= 16'd1;
                    end
                end
                WAIT_I, WAIT_D: begin
                    if (done) begin
                        state         <= IDLE;
                        store_pending <= 1'b0;
                        wait_count    <= '0;
                    end else if (wait_count != 16'hFFFF) begin
                        wait_count <= wait_count + 16'd1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    wait_count <= '0;
                end
            endcase
        end
    end

    // Trace controls belong to the simulation environment; hardware only ties them off.
    logic unused_trace;
    assign unused_trace = scan ^ (CORE != 0) ^ (SCAN_CYCLES_MIN > SCAN_CYCLES_MAX);

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the arbitration and response rules.
module tb_memory_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          i_read, i_ready, i_valid, i_page_fault, i_access_fault;
    logic [AW-1:0] i_address;
    logic [DW-1:0] i_data;
    logic          d_read, d_write, d_ready, d_valid, d_page_fault, d_access_fault;
    logic [AW-1:0] d_address;
    logic [DW-1:0] d_data_in, d_data;
    logic          mem_read, mem_write, mem_ready, mem_valid, page_fault, access_fault;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_out, mem_data_in;
    logic          scan;

    memory_port_arbiter #(
        .CORE(0), .ADDRESS_BITS(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO),
        .SCAN_CYCLES_MIN(0), .SCAN_CYCLES_MAX(1000)
    ) dut (
        .clock(clock), .reset(reset),
        .i_read(i_read), .i_address(i_address), .i_ready(i_ready), .i_valid(i_valid),
        .i_data(i_data), .i_page_fault(i_page_fault), .i_access_fault(i_access_fault),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_data_in(d_data_in),
        .d_ready(d_ready), .d_valid(d_valid), .d_data(d_data),
        .d_page_fault(d_page_fault), .d_access_fault(d_access_fault),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_data_out(mem_data_out), .mem_ready(mem_ready), .mem_valid(mem_valid),
        .mem_data_in(mem_data_in), .page_fault(page_fault), .access_fault(access_fault),
        .scan(scan)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Model: who owns the port (0 none, 1 fetch, 2 data), who won last,
    // the cycle number of the grant and whether the data transaction is a store.
    int owner       = 0;
    int last_winner = 2;
    int grant_cycle = 0;
    int cycle_no    = 0;
    bit own_store   = 0;
    int win         = 0;
    bit finish      = 0;
    int dut_grants[$];

    task automatic idle_inputs();
        i_read = 0; i_address = '0;
        d_read = 0; d_write = 0; d_address = '0; d_data_in = '0;
        mem_ready = 0; mem_valid = 0; mem_data_in = '0;
        page_fault = 0; access_fault = 0;
    endtask

    // Compare every DUT output against the model for the inputs currently applied.
    task automatic settle();
        logic [3:0]    e_strobe;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic [2:0]    e_i, e_d;
        logic [DW-1:0] e_idata, e_ddata;
        bit            resp, to;
        logic [DW-1:0] rdata;
        #1;
        e_strobe = '0; e_addr = '0; e_wdata = '0;
        e_i = '0; e_d = '0; e_idata = '0; e_ddata = '0;
        win = 0; finish = 0;
        if (!reset) begin
            if (owner == 0) begin
                if (mem_ready) begin
                    if (i_read && (d_read || d_write)) win = (last_winner == 2) ? 1 : 2;
                    else if (i_read)                   win = 1;
                    else if (d_read || d_write)        win = 2;
                end
                if (win == 1) begin
                    e_strobe = 4'b1010;   // {mem_read, mem_write, i_ready, d_ready}
                    e_addr   = i_address;
                end else if (win == 2) begin
                    e_strobe = {d_read, d_write, 1'b0, 1'b1};
                    e_addr   = d_address;
                    e_wdata  = d_write ? d_data_in : '0;
                end
            end else begin
                resp   = mem_valid || page_fault || access_fault;
                to     = !resp && (cycle_no - grant_cycle == TO);
                finish = resp || to;
                rdata  = resp ? mem_data_in : '0;
                if (finish) begin
                    if (owner == 1) begin
                        e_i     = {1'b1, resp && page_fault, resp ? access_fault : 1'b1};
                        e_idata = rdata;
                    end else begin
                        e_d     = {1'b1, resp && page_fault, resp ? access_fault : 1'b1};
                        e_ddata = own_store ? '0 : rdata;
                    end
                end
            end
        end
        check("strobes", {mem_read, mem_write, i_ready, d_ready}, e_strobe);
        check("mem_address", mem_address, e_addr);
        check("mem_data_out", mem_data_out, e_wdata);
        check("i_resp", {i_valid, i_page_fault, i_access_fault}, e_i);
        check("i_data", i_data, e_idata);
        check("d_resp", {d_valid, d_page_fault, d_access_fault}, e_d);
        check("d_data", d_data, e_ddata);
        if (i_ready) dut_grants.push_back(1);
        if (d_ready) dut_grants.push_back(2);
    endtask

    task automatic advance();
        @(posedge clock);
        if (reset) begin
            owner = 0; last_winner = 2; own_store = 0;
        end else if (win != 0) begin
            owner = win; last_winner = win; grant_cycle = cycle_no;
            own_store = (win == 2) && d_write;
        end else if (finish) begin
            owner = 0;
        end
        cycle_no++;
        @(negedge clock);
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic pulse_reset();
        idle_inputs();
        reset = 1;
        step();
        reset = 0;
    endtask

    bit            i_pend, d_pend;
    int            r;

    initial begin
        scan = 0;
        idle_inputs();
        reset = 1;
        @(negedge clock);
        settle();
        check("reset_outputs_zero", {mem_read, mem_write, i_ready, d_ready, i_valid, d_valid}, 6'b0);
        advance();
        reset = 0;
        step();

        // Single fetch with response three cycles after issue.
        i_read = 1; i_address = 32'h100; mem_ready = 1;
        settle();
        check("fetch_grant", {i_ready, mem_read, mem_address}, {2'b11, 32'h100});
        advance();
        i_read = 0; i_address = '0;
        step(); step();
        mem_valid = 1; mem_data_in = 32'h13;
        settle();
        check("fetch_resp", {i_valid, i_data}, {1'b1, 32'h13});
        check("fetch_d_quiet", {d_valid, d_data}, '0);
        advance();
        mem_valid = 0;

        // Conflict fairness after reset: I, D, I, D.
        pulse_reset();
        dut_grants.delete();
        i_read = 1; d_read = 1; i_address = 32'h40; d_address = 32'h80;
        mem_ready = 1; mem_valid = 1; mem_data_in = 32'h1234;
        for (int k = 0; k < 8; k++) step();
        check("fair_count", dut_grants.size(), 4);
        for (int k = 0; k < 4 && k < dut_grants.size(); k++)
            check("fair_order", dut_grants[k], (k % 2 == 0) ? 1 : 2);
        idle_inputs();
        step();

        // Store with ack.
        mem_ready = 1; d_write = 1; d_address = 32'h2000; d_data_in = 32'hDEADBEEF;
        settle();
        check("store_issue", {mem_write, mem_data_out}, {1'b1, 32'hDEADBEEF});
        advance();
        idle_inputs();
        mem_valid = 1; mem_data_in = 32'h5555AAAA;
        settle();
        check("store_ack", {d_valid, d_data}, {1'b1, 32'h0});
        advance();
        idle_inputs();

        // Page fault on a data read, then port free on the next cycle.
        mem_ready = 1; d_read = 1; d_address = 32'h3000;
        step();
        d_read = 0; page_fault = 1;
        settle();
        check("dfault", {d_valid, d_page_fault, i_page_fault}, 3'b110);
        advance();
        page_fault = 0; d_read = 1; d_address = 32'h3004;
        settle();
        check("idle_after_fault", d_ready, 1'b1);
        advance();
        idle_inputs();
        mem_valid = 1;
        step();
        idle_inputs();

        // Watchdog: fetch never answered.
        mem_ready = 1; i_read = 1; i_address = 32'h500;
        step();
        idle_inputs();
        for (int k = 1; k < TO; k++) begin
            settle();
            check("wd_quiet", i_valid, 1'b0);
            advance();
        end
        settle();
        check("wd_fire", {i_valid, i_access_fault, i_page_fault, i_data}, {3'b110, 32'h0});
        advance();
        mem_valid = 1; mem_data_in = 32'hFFFF;
        settle();
        check("wd_late_drop", {i_valid, d_valid}, 2'b00);
        advance();
        idle_inputs();

        // Reset in the middle of a data transaction.
        mem_ready = 1; d_read = 1; d_address = 32'h4000;
        step();
        d_read = 0; mem_ready = 0;
        reset = 1;
        settle();
        check("rst_mid_outputs", {i_valid, d_valid, d_ready, i_ready, mem_read}, 5'b0);
        advance();
        reset = 0; mem_valid = 1; mem_data_in = 32'h77;
        settle();
        check("rst_late_drop", d_valid, 1'b0);
        advance();
        idle_inputs();
        mem_ready = 1; i_read = 1; d_read = 1;
        settle();
        check("rst_conflict_i", {i_ready, d_ready}, 2'b10);
        advance();
        idle_inputs();
        pulse_reset();

        // Randomized traffic.
        i_pend = 0; d_pend = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1; i_read = 1; i_address = $urandom;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1; d_address = $urandom; d_data_in = $urandom;
                if ($urandom_range(0, 1) == 0) begin d_read = 1; d_write = 0; end
                else begin d_read = 0; d_write = 1; end
            end
            mem_ready   = ($urandom_range(0, 3) != 0);
            mem_data_in = $urandom;
            r = $urandom_range(0, 9);
            mem_valid    = (r == 0) || (r == 3);
            page_fault   = (r == 1);
            access_fault = (r == 2) || (r == 3);
            reset        = ($urandom_range(0, 399) == 0);
            settle();
            if (reset) begin
                i_pend = 0; d_pend = 0;
            end
            if (win == 1) i_pend = 0;
            if (win == 2) d_pend = 0;
            advance();
            reset = 0;
            if (!i_pend) i_read = 0;
            if (!d_pend) begin d_read = 0; d_write = 0; end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/memory_port_arbiter.md
# memory_port_arbiter

Shares one memory-hierarchy port between the instruction-fetch side and the data (load/store) side of a core. Grants one transaction at a time with round-robin fairness on conflict, holds ownership until the response or a fault returns, and routes data and fault status back to the owner. A watchdog timeout converts a hung transaction into an access fault. The hazard detection logic consumes the fault status so the pipeline can release its stall and take the exception.

## Interface
- CORE, 0, core index for scan output
- ADDRESS_BITS, 32, address width
- DATA_WIDTH, 32, data width
- TIMEOUT_CYCLES, 1024, max wait cycles before forced fault; 0 disables the watchdog
- SCAN_CYCLES_MIN, 0, first cycle of scan display
- SCAN_CYCLES_MAX, 1000, last cycle of scan display

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-high
- i_read  in  1  fetch request
- i_address  in  ADDRESS_BITS  fetch address
- i_ready  out  1  fetch request accepted this cycle
- i_valid  out  1  fetch response (data or fault) this cycle
- i_data  out  DATA_WIDTH  fetch response data
- i_page_fault, i_access_fault  out  1 each  fault on fetch transaction
- d_read, d_write  in  1 each  data request; never both high
- d_address  in  ADDRESS_BITS  data address
- d_data_in  in  DATA_WIDTH  store data
- d_ready  out  1  data request accepted this cycle
- d_valid  out  1  data response or store ack this cycle
- d_data  out  DATA_WIDTH  load response data
- d_page_fault, d_access_fault  out  1 each  fault on data transaction
- mem_read, mem_write  out  1 each  downstream request strobes
- mem_address  out  ADDRESS_BITS  downstream address
- mem_data_out  out  DATA_WIDTH  downstream store data
- mem_ready  in  1  downstream can accept a request
- mem_valid  in  1  downstream response or ack
- mem_data_in  in  DATA_WIDTH  downstream response data
- page_fault, access_fault  in  1 each  downstream fault, valid only while a transaction is outstanding
- scan  in  1  enables $display trace within the configured cycle window

## Operation
- FSM states: IDLE, WAIT_I, WAIT_D. Register last_grant (I/D); wait counter of 16 bits.
- IDLE, mem_ready=1:
  - Only I requests: grant I.
  - Only D requests: grant D.
  - Both request: grant the side not equal to last_grant.
- Grant is combinational in the same cycle:
  - mem_read/mem_write, mem_address and mem_data_out (D writes only) driven from the winner.
  - Winner's i_ready or d_ready = 1.
  - Next state is WAIT_I or WAIT_D; last_grant updates to the winner.
- IDLE, mem_ready=0 or no request: no strobes, no ready asserted, stay in IDLE.
- WAIT_x:
  - Strobes low.
  - If mem_valid, page_fault or access_fault: owner's valid=1 in the same cycle, owner's data = mem_data_in, and the fault inputs pass to the owner's fault outputs; next state IDLE.
  - Otherwise stay; counter increments.
- Watchdog: with TIMEOUT_CYCLES≠0, when the counter reaches TIMEOUT_CYCLES in WAIT_x, the owner gets valid=1 and access_fault=1 that cycle, then the FSM goes to IDLE. The counter clears on entering IDLE.
- Non-owner valid, fault outputs and data are always 0. i_data and d_data are 0 whenever the corresponding valid is 0.
- Inputs ignored in IDLE: mem_valid, page_fault, access_fault. A stray or late response is dropped.
- Store completes on mem_valid (ack); d_data content is don't-care but forced to 0.

## Timing
- Reset (async): state IDLE, last_grant=D (so I wins the first conflict), counter 0. All outputs are 0 while reset is high and after reset until a request arrives.
- Issue latency: 0 cycles (request and grant in the same cycle when IDLE and mem_ready=1).
- Response latency through the block: 0 cycles (combinational pass-through).
- Minimum spacing between grants: 2 cycles (the response cycle returns to IDLE; the next grant is on the following cycle).
- Requesters hold request and address until they see ready=1.
- Reset asserted mid-transaction: the transaction is abandoned, no valid is issued for it, and any late mem_valid lands in IDLE and is dropped.
- Response and watchdog expiry in the same cycle: normal response wins and fault outputs follow the inputs; no timeout fault is raised.

## Test plan
- Single fetch: i_read=1, i_address=0x100, mem_ready=1 → i_ready=1 and mem_read=1 with mem_address=0x100 that cycle; mem_valid with data 0x00000013 three cycles later → i_valid=1 and i_data=0x13 that cycle, d_* outputs stay 0.
- Conflict fairness: i_read and d_read held continuously, every response returned one cycle after issue → grants alternate I, D, I, D starting with I after reset.
- Store: d_write=1, d_address=0x2000, d_data_in=0xDEADBEEF → mem_write=1 and mem_data_out=0xDEADBEEF; ack → d_valid=1, d_data=0.
- Faults: D read outstanding with page_fault=1 → d_valid=1 and d_page_fault=1, i_page_fault=0; FSM in IDLE next cycle.
- Watchdog: TIMEOUT_CYCLES=8, fetch granted and no response → i_valid=1 and i_access_fault=1 exactly 8 cycles after grant; a mem_valid arriving afterwards is ignored.
- Reset mid-transaction: reset pulse while in WAIT_D → all outputs 0; a later mem_valid produces no d_valid; next conflict grants I.
